// File: rtl/spy_path_prober.sv
// spy_path_prober: launches alternating edges into a delay-chain path,
// synchronises the chain output and measures the per-trial latency in clock
// cycles. Reports last/min/max latency and a saturating latency sum.
// SYNC_STAGES must be at least 2.
module spy_path_prober #(
   parameter int CNT_W         = 16,
   parameter int TRIAL_W       = 8,
   parameter int SUM_W         = 24,
   parameter int SYNC_STAGES   = 2,
   parameter int TIMEOUT       = 1000,
   parameter int CHAIN_INVERTS = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [TRIAL_W-1:0] trials,
   output logic               path_in,
   input  logic               path_out,
   output logic               busy,
   output logic               done,
   output logic               timeout_err,
   output logic [TRIAL_W-1:0] trials_done,
   output logic [CNT_W-1:0]   last_cnt,
   output logic [CNT_W-1:0]   min_cnt,
   output logic [CNT_W-1:0]   max_cnt,
   output logic [SUM_W-1:0]   sum_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_LAUNCH  = 3'd2,
      S_MEASURE = 3'd3,
      S_RECORD  = 3'd4,
      S_ABORT   = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic             C_INV     = (CHAIN_INVERTS != 0);

   state_t r_state;
   state_t w_state_next;

   logic                   r_path_in;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   logic [TRIAL_W-1:0]     r_trials_lat;
   logic [TRIAL_W-1:0]     r_trials_done;
   logic [CNT_W-1:0]       r_last;
   logic [CNT_W-1:0]       r_min;
   logic [CNT_W-1:0]       r_max;
   logic [SUM_W-1:0]       r_sum;
   logic                   r_timeout_err;

   logic                   w_exp;
   logic                   w_sync_q;
   logic                   w_match;
   logic                   w_timer_hit;
   logic                   w_cnt_sat;
   logic [TRIAL_W-1:0]     w_trials_eff;
   logic [TRIAL_W-1:0]     w_trials_inc;
   logic                   w_last_trial;
   logic [SUM_W:0]         w_sum_ext;

   // The chain output is expected to settle at the driven level, optionally inverted.
   assign w_exp        = r_path_in ^ C_INV;
   assign w_sync_q     = r_sync[SYNC_STAGES-1];
   assign w_match      = (w_sync_q == w_exp);
   assign w_timer_hit  = (r_cnt >= C_TIMEOUT);
   assign w_cnt_sat    = &r_cnt;
   assign w_trials_eff = (trials == '0) ? TRIAL_W'(1) : trials;
   assign w_trials_inc = r_trials_done + TRIAL_W'(1);
   assign w_last_trial = (w_trials_inc == r_trials_lat);
   // One extra bit catches overflow of the running sum.
   assign w_sum_ext    = {1'b0, r_sum} + (SUM_W+1)'(r_cnt);

   assign path_in     = r_path_in;
   assign timeout_err = r_timeout_err;
   assign trials_done = r_trials_done;
   assign last_cnt    = r_last;
   assign min_cnt     = r_min;
   assign max_cnt     = r_max;
   assign sum_cnt     = r_sum;

   // Synchroniser shift register for the asynchronous chain output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], path_out};
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; a match always wins over a simultaneous timeout.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (w_match) begin
               w_state_next = S_LAUNCH;
            end else if (w_timer_hit) begin
               w_state_next = S_ABORT;
            end
         end
         S_LAUNCH: begin
            w_state_next = S_MEASURE;
         end
         S_MEASURE: begin
            if (w_match) begin
               w_state_next = S_RECORD;
            end else if (w_timer_hit) begin
               w_state_next = S_ABORT;
            end
         end
         S_RECORD: begin
            w_state_next = w_last_trial ? S_DONE : S_SETTLE;
         end
         S_ABORT: begin
            w_state_next = S_DONE;
         end
         S_DONE: begin
            // start seen here is dropped; it is accepted again from IDLE
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         S_SETTLE, S_LAUNCH, S_MEASURE, S_RECORD, S_ABORT: busy = 1'b1;
         S_DONE:                                            done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: shared timer, chain drive and result accumulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_path_in     <= 1'b0;
         r_cnt         <= '0;
         r_trials_lat  <= '0;
         r_trials_done <= '0;
         r_last        <= '0;
         r_min         <= '1;
         r_max         <= '0;
         r_sum         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_trials_lat  <= w_trials_eff;
                  r_trials_done <= '0;
                  r_last        <= '0;
                  r_min         <= '1;
                  r_max         <= '0;
                  r_sum         <= '0;
                  r_timeout_err <= 1'b0;
                  r_cnt         <= '0;
               end
            end
            S_SETTLE, S_MEASURE: begin
               // Hold the count on the matching cycle so RECORD sees the latency.
               if (!w_match && !w_timer_hit && !w_cnt_sat) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_LAUNCH: begin
               // Polarity alternates between trials; path_in is never re-zeroed.
               r_path_in <= ~r_path_in;
               r_cnt     <= '0;
            end
            S_RECORD: begin
               r_last        <= r_cnt;
               r_min         <= (r_cnt < r_min) ? r_cnt : r_min;
               r_max         <= (r_cnt > r_max) ? r_cnt : r_max;
               r_sum         <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
               r_trials_done <= w_trials_inc;
               r_cnt         <= '0;
            end
            S_ABORT: begin
               r_timeout_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
